// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 complex butterfly with per-sample DIT/DIF mode, rounding,
// optional halving, saturation, sticky overflow and a valid/ready handshake.
module butterfly_pipe #(
   parameter int DATA_W = 16,
   parameter int TW_W   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [2*DATA_W-1:0] in_a,
   input  logic [2*DATA_W-1:0] in_b,
   input  logic [2*TW_W-1:0]   in_w,
   input  logic                in_dif,
   input  logic                in_scale,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*DATA_W-1:0] out_x,
   output logic [2*DATA_W-1:0] out_y,
   output logic                ovf,
   input  logic                ovf_clr
);

   localparam int AW  = DATA_W + 1;          // DIF sum/difference, multiplier data operand
   localparam int PW  = DATA_W + 2;          // stage-1 value: DIT product or DIF sum
   localparam int VW  = DATA_W + 3;          // stage-2 value: wide enough for DIF d*w
   localparam int PRW = DATA_W + TW_W + 1;
   localparam int MW  = DATA_W + TW_W + 2;

   localparam logic signed [MW-1:0] RND_HALF = MW'(1) <<< (TW_W - 2);
   localparam logic signed [VW-1:0] SAT_MAX  = VW'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
   localparam logic signed [VW-1:0] SAT_MIN  = -SAT_MAX - VW'(1);

   function automatic logic signed [VW-1:0] round_q(input logic signed [MW-1:0] v);
      logic signed [MW-1:0] t;
      t = v + RND_HALF;
      return VW'(t >>> (TW_W - 1));
   endfunction

   // Full-precision complex product x*w; real and imag each rounded exactly once.
   function automatic logic [2*VW-1:0] cmul_round(
      input logic signed [AW-1:0]   xr,
      input logic signed [AW-1:0]   xi,
      input logic signed [TW_W-1:0] wr,
      input logic signed [TW_W-1:0] wi
   );
      logic signed [PRW-1:0] p_rr;
      logic signed [PRW-1:0] p_ii;
      logic signed [PRW-1:0] p_ri;
      logic signed [PRW-1:0] p_ir;
      p_rr = PRW'(xr) * PRW'(wr);
      p_ii = PRW'(xi) * PRW'(wi);
      p_ri = PRW'(xr) * PRW'(wi);
      p_ir = PRW'(xi) * PRW'(wr);
      return {round_q(MW'(p_rr) - MW'(p_ii)), round_q(MW'(p_ri) + MW'(p_ir))};
   endfunction

   // Pipeline state
   logic                   s1_valid_q, s1_valid_d;
   logic                   s1_dif_q, s1_dif_d;
   logic                   s1_scale_q, s1_scale_d;
   logic signed [PW-1:0]   s1_u_re_q, s1_u_re_d, s1_u_im_q, s1_u_im_d;
   logic signed [AW-1:0]   s1_v_re_q, s1_v_re_d, s1_v_im_q, s1_v_im_d;
   logic signed [TW_W-1:0] s1_w_re_q, s1_w_re_d, s1_w_im_q, s1_w_im_d;

   logic                   s2_valid_q, s2_valid_d;
   logic                   s2_scale_q, s2_scale_d;
   logic signed [VW-1:0]   s2_c_q [4];
   logic signed [VW-1:0]   s2_c_d [4];

   logic                   out_valid_q, out_valid_d;
   logic [2*DATA_W-1:0]    out_x_q, out_x_d;
   logic [2*DATA_W-1:0]    out_y_q, out_y_d;
   logic                   ovf_q, ovf_d;

   logic adv;
   assign adv      = out_ready || !out_valid_q;
   assign in_ready = adv;

   logic signed [AW-1:0]   a_re, a_im, b_re, b_im;
   logic signed [TW_W-1:0] w_re, w_im;
   logic signed [AW-1:0]   sum_re, sum_im, diff_re, diff_im;

   always_comb begin
      a_re    = AW'($signed(in_a[2*DATA_W-1:DATA_W]));
      a_im    = AW'($signed(in_a[DATA_W-1:0]));
      b_re    = AW'($signed(in_b[2*DATA_W-1:DATA_W]));
      b_im    = AW'($signed(in_b[DATA_W-1:0]));
      w_re    = $signed(in_w[2*TW_W-1:TW_W]);
      w_im    = $signed(in_w[TW_W-1:0]);
      sum_re  = a_re + b_re;
      sum_im  = a_im + b_im;
      diff_re = a_re - b_re;
      diff_im = a_im - b_im;
   end

   logic [2*VW-1:0] p_dit;
   assign p_dit = cmul_round(b_re, b_im, w_re, w_im);

   // Stage 1: DIT forms p = round(b*w) and carries a; DIF forms a+b and a-b and carries w.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_dif_d   = s1_dif_q;
      s1_scale_d = s1_scale_q;
      s1_u_re_d  = s1_u_re_q;
      s1_u_im_d  = s1_u_im_q;
      s1_v_re_d  = s1_v_re_q;
      s1_v_im_d  = s1_v_im_q;
      s1_w_re_d  = s1_w_re_q;
      s1_w_im_d  = s1_w_im_q;
      if (adv) begin
         s1_valid_d = in_valid;
         s1_dif_d   = in_dif;
         s1_scale_d = in_scale;
         s1_w_re_d  = w_re;
         s1_w_im_d  = w_im;
         if (in_dif) begin
            s1_u_re_d = PW'(sum_re);
            s1_u_im_d = PW'(sum_im);
            s1_v_re_d = diff_re;
            s1_v_im_d = diff_im;
         end else begin
            s1_u_re_d = PW'($signed(p_dit[2*VW-1:VW]));
            s1_u_im_d = PW'($signed(p_dit[VW-1:0]));
            s1_v_re_d = a_re;
            s1_v_im_d = a_im;
         end
      end
   end

   logic [2*VW-1:0] y_dif;
   assign y_dif = cmul_round(s1_v_re_q, s1_v_im_q, s1_w_re_q, s1_w_im_q);

   // Stage 2: components ordered {x_re, x_im, y_re, y_im}.
   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_scale_d = s2_scale_q;
      s2_c_d     = s2_c_q;
      if (adv) begin
         s2_valid_d = s1_valid_q;
         s2_scale_d = s1_scale_q;
         if (s1_dif_q) begin
            s2_c_d[0] = VW'(s1_u_re_q);
            s2_c_d[1] = VW'(s1_u_im_q);
            s2_c_d[2] = $signed(y_dif[2*VW-1:VW]);
            s2_c_d[3] = $signed(y_dif[VW-1:0]);
         end else begin
            s2_c_d[0] = VW'(s1_v_re_q) + VW'(s1_u_re_q);
            s2_c_d[1] = VW'(s1_v_im_q) + VW'(s1_u_im_q);
            s2_c_d[2] = VW'(s1_v_re_q) - VW'(s1_u_re_q);
            s2_c_d[3] = VW'(s1_v_im_q) - VW'(s1_u_im_q);
         end
      end
   end

   // Stage 3 per-component halving (round half up) and saturation.
   logic [DATA_W-1:0] res_c [4];
   logic [3:0]        clamp_c;

   for (genvar gi = 0; gi < 4; gi++) begin : g_sat
      logic signed [VW-1:0] scaled;
      logic                 hi, lo;
      assign scaled      = s2_scale_q ? (s2_c_q[gi] + VW'(1)) >>> 1 : s2_c_q[gi];
      assign hi          = scaled > SAT_MAX;
      assign lo          = scaled < SAT_MIN;
      assign clamp_c[gi] = hi || lo;
      assign res_c[gi]   = hi ? SAT_MAX[DATA_W-1:0] :
                           lo ? SAT_MIN[DATA_W-1:0] : scaled[DATA_W-1:0];
   end

   // A clamp on a sample entering the output register outranks a same-cycle clear.
   always_comb begin
      out_valid_d = out_valid_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      ovf_d       = ovf_q;
      if (adv) begin
         out_valid_d = s2_valid_q;
         out_x_d     = {res_c[0], res_c[1]};
         out_y_d     = {res_c[2], res_c[3]};
      end
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end
      if (adv && s2_valid_q && (|clamp_c)) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_dif_q    <= 1'b0;
         s1_scale_q  <= 1'b0;
         s1_u_re_q   <= '0;
         s1_u_im_q   <= '0;
         s1_v_re_q   <= '0;
         s1_v_im_q   <= '0;
         s1_w_re_q   <= '0;
         s1_w_im_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_scale_q  <= 1'b0;
         s2_c_q      <= '{default: '0};
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_dif_q    <= s1_dif_d;
         s1_scale_q  <= s1_scale_d;
         s1_u_re_q   <= s1_u_re_d;
         s1_u_im_q   <= s1_u_im_d;
         s1_v_re_q   <= s1_v_re_d;
         s1_v_im_q   <= s1_v_im_d;
         s1_w_re_q   <= s1_w_re_d;
         s1_w_im_q   <= s1_w_im_d;
         s2_valid_q  <= s2_valid_d;
         s2_scale_q  <= s2_scale_d;
         s2_c_q      <= s2_c_d;
         out_valid_q <= out_valid_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         ovf_q       <= ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_x     = out_x_q;
   assign out_y     = out_y_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Self-checking bench for butterfly_pipe: arithmetic reference model with a scoreboard,
// plus directed vectors with hand-computed results.
module tb_butterfly_pipe;

   logic        clk = 1'b0;
   logic        rst_n, in_valid, in_ready, in_dif, in_scale;
   logic        out_valid, out_ready, ovf, ovf_clr;
   logic [31:0] in_a, in_b, in_w, out_x, out_y;

   always #5 clk = ~clk;

   butterfly_pipe #(.DATA_W(16), .TW_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_w(in_w),
      .in_dif(in_dif), .in_scale(in_scale),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y),
      .ovf(ovf), .ovf_clr(ovf_clr)
   );

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
      bit          sat;
   } exp_t;

   exp_t exp_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Round half up of v / 2^15.
   function automatic longint rnd(input longint v);
      return (v + 64'sd16384) >>> 15;
   endfunction

   // Optional halving then clamp to 16 bits; bit 16 flags a clamp.
   function automatic logic [16:0] fin(input longint v, input bit scale);
      longint t;
      t = scale ? ((v + 1) >>> 1) : v;
      if (t > 32767)  return {1'b1, 16'h7FFF};
      if (t < -32768) return {1'b1, 16'h8000};
      return {1'b0, t[15:0]};
   endfunction

   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] w, input bit dif, input bit scale);
      longint ar, ai, br, bi, wr, wi, pr, pi, xr, xi, yr, yi;
      logic [16:0] r0, r1, r2, r3;
      exp_t e;
      ar = $signed(a[31:16]); ai = $signed(a[15:0]);
      br = $signed(b[31:16]); bi = $signed(b[15:0]);
      wr = $signed(w[31:16]); wi = $signed(w[15:0]);
      if (!dif) begin
         pr = rnd(br * wr - bi * wi);
         pi = rnd(br * wi + bi * wr);
         xr = ar + pr; xi = ai + pi;
         yr = ar - pr; yi = ai - pi;
      end else begin
         xr = ar + br; xi = ai + bi;
         pr = ar - br; pi = ai - bi;
         yr = rnd(pr * wr - pi * wi);
         yi = rnd(pr * wi + pi * wr);
      end
      r0 = fin(xr, scale); r1 = fin(xi, scale);
      r2 = fin(yr, scale); r3 = fin(yi, scale);
      e.x   = {r0[15:0], r1[15:0]};
      e.y   = {r2[15:0], r3[15:0]};
      e.sat = r0[16] | r1[16] | r2[16] | r3[16];
      return e;
   endfunction

   // One clock: called at a falling edge with inputs already set, returns at the next one.
   task automatic step(output bit acc);
      #1;
      acc = in_valid && in_ready && rst_n;
      @(posedge clk);
      if (acc) exp_q.push_back(model(in_a, in_b, in_w, in_dif, in_scale));
      @(negedge clk);
   endtask

   task automatic send_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] w, input bit dif, input bit scale,
                           input logic [31:0] ex, input logic [31:0] ey);
      bit acc;
      int n;
      in_a = a; in_b = b; in_w = w; in_dif = dif; in_scale = scale;
      in_valid = 1'b1; out_ready = 1'b1;
      step(acc);
      in_valid = 1'b0;
      chk({name, "_accept"}, acc, 1'b1);
      n = 1;
      while (!out_valid && n < 10) begin
         step(acc);
         n++;
      end
      chk({name, "_latency"}, n, 3);
      chk({name, "_x"}, out_x, ex);
      chk({name, "_y"}, out_y, ey);
      step(acc);
   endtask

   // Per-cycle compare against the scoreboard, handshake rule and hold-under-stall rule.
   initial begin
      exp_t        e;
      bit          held;
      logic [31:0] hx, hy;
      held = 1'b0;
      hx = '0;
      hy = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
            continue;
         end
         chk("in_ready_rule", in_ready, out_ready || !out_valid);
         if (held && out_valid) begin
            chk("stall_hold_x", out_x, hx);
            chk("stall_hold_y", out_y, hy);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output: got x=%h y=%h expected no sample", out_x, out_y);
            end else begin
               e = exp_q.pop_front();
               chk("model_x", out_x, e.x);
               chk("model_y", out_y, e.y);
               if (e.sat) chk("ovf_after_sat", ovf, 1'b1);
            end
         end
         held = out_valid && !out_ready;
         hx = out_x;
         hy = out_y;
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   logic [31:0] ta [6];
   logic [31:0] tb [6];
   logic [31:0] tw [6];
   bit          td [6];
   bit          ts [6];

   initial begin
      bit acc;
      int sent, stall_left, cyc;

      ta[0] = {16'd1000, 16'hF830};  tb[0] = {16'd300, 16'd400};   tw[0] = 32'h5A82_A57E; td[0] = 0; ts[0] = 0;
      ta[1] = {16'hFE0C, 16'd700};   tb[1] = {16'd250, 16'hFF83};  tw[1] = 32'h7FFF_0000; td[1] = 1; ts[1] = 1;
      ta[2] = {16'd12345, 16'hFEBF}; tb[2] = {16'hF060, 16'd2500}; tw[2] = 32'h0000_8000; td[2] = 0; ts[2] = 1;
      ta[3] = {16'd30000, 16'd30000}; tb[3] = {16'h8AD0, 16'h8AD0}; tw[3] = 32'h4000_4000; td[3] = 1; ts[3] = 0;
      ta[4] = 32'hFFFF_FFFF;         tb[4] = {16'd1, 16'd1};       tw[4] = 32'h7FFF_7FFF; td[4] = 0; ts[4] = 0;
      ta[5] = {16'd7, 16'hFFF8};     tb[5] = {16'd3, 16'd5};       tw[5] = 32'h8000_8000; td[5] = 1; ts[5] = 1;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
      in_a = '0; in_b = '0; in_w = '0; in_dif = 1'b0; in_scale = 1'b0;

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_x", out_x, 32'h0);
      chk("reset_out_y", out_y, 32'h0);
      chk("reset_ovf", ovf, 1'b0);
      chk("reset_in_ready", in_ready, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;

      // DIT, w = -1
      send_one("dit_basic", {16'd100, 16'd50}, {16'd20, 16'hFFF6}, 32'h8000_0000, 0, 0,
               {16'd80, 16'd60}, {16'd120, 16'd40});
      send_one("dit_scaled", {16'd100, 16'd50}, {16'd20, 16'hFFF6}, 32'h8000_0000, 0, 1,
               {16'd40, 16'd30}, {16'd60, 16'd20});
      chk("ovf_after_unsat", ovf, 1'b0);

      // Saturation and sticky overflow
      send_one("dit_sat", {16'h7FFF, 16'h0}, {16'h7FFF, 16'h0}, 32'h8000_0000, 0, 0,
               32'h0000_0000, {16'h7FFF, 16'h0});
      chk("ovf_sticky_set", ovf, 1'b1);
      ovf_clr = 1'b1;
      step(acc);
      ovf_clr = 1'b0;
      chk("ovf_cleared", ovf, 1'b0);

      // Bubbles carrying saturating garbage must not set ovf
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step(acc);
      chk("ovf_bubble_clamp", ovf, 1'b0);

      send_one("dit_sat_scaled", {16'h7FFF, 16'h0}, {16'h7FFF, 16'h0}, 32'h8000_0000, 0, 1,
               32'h0000_0000, {16'h7FFF, 16'h0});
      chk("ovf_scaled_no_sat", ovf, 1'b0);

      // DIF, w = -j
      send_one("dif_basic", {16'd10, 16'd3}, {16'd4, 16'd1}, 32'h0000_8000, 1, 0,
               {16'd14, 16'd4}, {16'd2, 16'hFFFA});

      // Back-to-back mixed-mode stream with a 5-cycle output stall
      sent = 0; stall_left = -1; cyc = 0;
      while ((sent < 6 || exp_q.size() > 0 || out_valid) && cyc < 100) begin
         if (stall_left < 0 && out_valid) stall_left = 5;
         out_ready = !(stall_left > 0);
         in_valid  = (sent < 6);
         if (sent < 6) begin
            in_a = ta[sent]; in_b = tb[sent]; in_w = tw[sent];
            in_dif = td[sent]; in_scale = ts[sent];
         end
         step(acc);
         if (acc) sent++;
         if (stall_left > 0) stall_left--;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("stream_no_timeout", cyc < 100, 1'b1);
      chk("stream_all_sent", sent, 6);
      chk("stream_all_out", exp_q.size(), 0);

      // Reset with three samples in flight
      in_a = {16'h7FFF, 16'h0}; in_b = {16'h7FFF, 16'h0}; in_w = 32'h8000_0000;
      in_dif = 1'b0; in_scale = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(acc);
         in_a = {16'd5, 16'd6};
         in_b = {16'd1, 16'd2};
      end
      in_valid = 1'b0;
      chk("pre_reset_out_valid", out_valid, 1'b1);
      chk("pre_reset_ovf", ovf, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_ovf", ovf, 1'b0);
      chk("midrst_out_x", out_x, 32'h0);
      chk("midrst_in_ready", in_ready, 1'b1);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(acc);
      chk("post_reset_no_ghost", out_valid, 1'b0);

      send_one("post_reset", {16'd100, 16'd50}, {16'd20, 16'hFFF6}, 32'h8000_0000, 0, 0,
               {16'd80, 16'd60}, {16'd120, 16'd40});

      // Clear held high while a saturating sample lands: the set wins, then the clear acts
      ovf_clr = 1'b1;
      in_a = {16'h7FFF, 16'h0}; in_b = {16'h7FFF, 16'h0}; in_w = 32'h8000_0000;
      in_dif = 1'b0; in_scale = 1'b0; in_valid = 1'b1;
      step(acc);
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 10) begin
         step(acc);
         cyc++;
      end
      chk("set_wins_valid", out_valid, 1'b1);
      chk("set_wins_ovf", ovf, 1'b1);
      step(acc);
      chk("clr_ovf", ovf, 1'b0);
      ovf_clr = 1'b0;

      for (int i = 0; i < 4; i++) step(acc);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
